iob_eth_rx_mac: RTL and testbench
=================================

IOB_ETH_RX_MAC -- requirements
Module: iob_eth_rx_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning PHY data width (4 = MII nibble mode, 8 = GMII byte mode; other values illegal).
REQ-002 SHALL have parameter BUF_ADDR_W, default 11, meaning frame buffer address width; max frame = 2^BUF_ADDR_W bytes.
REQ-003 SHALL have parameter MIN_LEN, default 64, meaning minimum legal frame length in bytes (DA through FCS).
REQ-004 SHALL have ports: clk_i  in  1  PHY receive clock, the only clock.
REQ-005 SHALL have ports: arst_n_i  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: rx_dv_i  in  1  data valid; rx_er_i  in  1  receive error; rx_data_i  in  DATA_W  PHY data.
REQ-007 SHALL have ports: filter_en_i  in  1  enable DA filtering; mac_addr_i  in  48  station address, byte 0 in [47:40].
REQ-008 SHALL have ports: wr_o  out  1  buffer write strobe; addr_o  out  BUF_ADDR_W  byte address; data_o  out  8  byte.
REQ-009 SHALL have ports: rcv_ack_i  in  1  frame consumed; data_rcvd_o  out  1  frame ready; len_o  out  BUF_ADDR_W+1  frame byte count.
REQ-010 SHALL have ports: crc_err_o  out  1; len_err_o  out  1; drop_cnt_o  out  16  dropped-frame counter.

Function
REQ-011 SHALL register rx_dv_i, rx_er_i, rx_data_i once before any use; all timing below is relative to the registered copies.
REQ-012 SHALL assemble bytes low nibble first when DATA_W=4 (byte = {new nibble, previous nibble}); one byte per cycle when DATA_W=8.
REQ-013 SHALL implement states IDLE, DATA, DONE, DROP; reset state IDLE.
REQ-014 IDLE: SHALL, while dv high, compare the assembled byte every cycle to 8'hD5; on match go to DATA with nibble phase aligned so the next byte completes 2 cycles (DATA_W=4) or 1 cycle (DATA_W=8) later.
REQ-015 DATA: SHALL, per completed byte, pulse wr_o for exactly 1 cycle with data_o = byte and addr_o = byte index (first DA byte at 0), and update an internal CRC-32.
REQ-016 SHALL compare bytes 0-5 to mac_addr_i and to FF:FF:FF:FF:FF:FF; if filter_en_i=1 and neither matches after byte 5 is written, go to DROP.
REQ-017 SHALL go to DROP if rx_er is high in DATA, or if a byte would be written at index 2^BUF_ADDR_W (no write occurs for it).
REQ-018 SHALL, on dv low in DATA, discard a trailing incomplete nibble, set len_o = bytes written, go to DONE.
REQ-019 SHALL set in DONE: crc_err_o = (CRC residue over all bytes incl. FCS != 32'hC704DD7B); len_err_o = (len_o < MIN_LEN).
REQ-020 DONE: SHALL hold data_rcvd_o=1, len_o, crc_err_o, len_err_o stable, and perform no writes until rcv_ack_i=1.
REQ-021 SHALL, on rcv_ack_i in DONE, clear data_rcvd_o next cycle and go to IDLE if dv low, else DROP; rcv_ack_i outside DONE SHALL be ignored.
REQ-022 DROP: SHALL never assert wr_o, increment drop_cnt_o once per entry (saturating at 16'hFFFF), return to IDLE when dv low.
REQ-023 SHALL keep addr_o at 0 in IDLE; CRC SHALL be re-initialised on every IDLE->DATA transition.
REQ-024 Frame starting in the same cycle as ack SHALL be handled per REQ-021 (dropped, counted).

Reset
REQ-025 SHALL on arst_n_i=0 immediately force state IDLE, wr_o=0, addr_o=0, data_o=0, data_rcvd_o=0, len_o=0, crc_err_o=0, len_err_o=0, drop_cnt_o=0, input registers 0.
REQ-026 SHALL, after reset release mid-frame, ignore the remainder of that frame until a new SFD is seen.

Verification
REQ-027 DATA_W=4, 7x55+D5 preamble, 64-byte valid frame, DA=mac_addr_i -> 64 wr_o pulses addr 0..63, len_o=64, crc_err_o=0, len_err_o=0, data_rcvd_o until ack.
REQ-028 DATA_W=8, same frame with one FCS bit flipped -> len_o=64, crc_err_o=1; 40-byte good frame -> len_err_o=1.
REQ-029 filter_en_i=1, DA mismatch -> exactly 6 writes, DROP, drop_cnt_o=1, no data_rcvd_o; broadcast DA -> accepted.
REQ-030 rx_er_i pulse at byte 20 -> DROP, drop_cnt_o increments, no DONE; BUF_ADDR_W=6 with 100-byte frame -> 64 writes then DROP.
REQ-031 Second frame during DONE, ack asserted while dv high -> no writes, drop_cnt_o+1, next frame after dv low received normally.
REQ-032 arst_n_i low at byte 30 -> all outputs 0 same cycle; after release, no writes until next SFD.

Source files
------------

// File: rtl/iob_eth_rx_mac.sv
// iob_eth_rx_mac: Ethernet receive MAC; strips preamble/SFD, writes frame bytes to a buffer,
// filters on destination address and checks FCS and length.
module iob_eth_rx_mac #(
    parameter int DATA_W     = 4,
    parameter int BUF_ADDR_W = 11,
    parameter int MIN_LEN    = 64
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  rx_dv_i,
    input  logic                  rx_er_i,
    input  logic [DATA_W-1:0]     rx_data_i,
    input  logic                  filter_en_i,
    input  logic [47:0]           mac_addr_i,
    output logic                  wr_o,
    output logic [BUF_ADDR_W-1:0] addr_o,
    output logic [7:0]            data_o,
    input  logic                  rcv_ack_i,
    output logic                  data_rcvd_o,
    output logic [BUF_ADDR_W:0]   len_o,
    output logic                  crc_err_o,
    output logic                  len_err_o,
    output logic [15:0]           drop_cnt_o
);

    typedef enum logic [1:0] {IDLE, DATA, DONE, DROP} state_t;

    state_t                state, nxt;
    logic                  dv_q, er_q;
    logic [DATA_W-1:0]     data_q;
    logic [7:0]            byte_w, mac_b;
    logic [47:0]           mac_sh;
    logic                  ph, byte_done, sfd, head, filt_fail, ovf;
    logic                  wr_d, to_done, to_drop;
    logic [BUF_ADDR_W:0]   cnt;
    logic [31:0]           crc;
    logic                  uc_ok, bc_ok;

    // MSB-first register fed with each byte LSB first; good-frame residue is C704DD7B
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[30:0], 1'b0} ^ ((r[31] ^ b[i]) ? 32'h04C1_1DB7 : 32'h0);
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            dv_q   <= 1'b0;
            er_q   <= 1'b0;
            data_q <= '0;
        end else begin
            dv_q   <= rx_dv_i;
            er_q   <= rx_er_i;
            data_q <= rx_data_i;
        end
    end

    generate
        if (DATA_W == 8) begin : g_byte
            assign byte_w = data_q;
        end else begin : g_nib
            logic [3:0] nib;
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i)
                    nib <= 4'h0;
                else
                    nib <= data_q;
            end
            assign byte_w = {data_q, nib};
        end
    endgenerate

    assign byte_done = dv_q && (DATA_W == 8 || ph);
    assign sfd       = dv_q && byte_w == 8'hD5;
    assign head      = cnt < (BUF_ADDR_W+1)'(6);
    assign mac_sh    = mac_addr_i << {cnt[2:0], 3'b000};
    assign mac_b     = mac_sh[47:40];
    assign filt_fail = filter_en_i && cnt == (BUF_ADDR_W+1)'(6) && !(uc_ok || bc_ok);
    assign ovf       = byte_done && cnt[BUF_ADDR_W];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = sfd ? DATA : IDLE;
            DATA: nxt = (er_q || filt_fail || ovf) ? DROP : !dv_q ? DONE : DATA;
            DONE: nxt = !rcv_ack_i ? DONE : dv_q ? DROP : IDLE;
            DROP: nxt = dv_q ? DROP : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_d    = state == DATA && nxt == DATA && byte_done;
        to_done = state == DATA && nxt == DONE;
        to_drop = state != DROP && nxt == DROP;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ph          <= 1'b0;
            cnt         <= '0;
            crc         <= '1;
            uc_ok       <= 1'b1;
            bc_ok       <= 1'b1;
            wr_o        <= 1'b0;
            addr_o      <= '0;
            data_o      <= '0;
            data_rcvd_o <= 1'b0;
            len_o       <= '0;
            crc_err_o   <= 1'b0;
            len_err_o   <= 1'b0;
            drop_cnt_o  <= '0;
        end else begin
            ph          <= state == DATA ? ~ph : 1'b0;
            wr_o        <= wr_d;
            data_rcvd_o <= nxt == DONE;
            if (state == IDLE) begin
                cnt   <= '0;
                crc   <= '1;
                uc_ok <= 1'b1;
                bc_ok <= 1'b1;
            end else if (wr_d) begin
                cnt <= cnt + 1'b1;
                crc <= crc_step(crc, byte_w);
                if (head) begin
                    uc_ok <= uc_ok & (byte_w == mac_b);
                    bc_ok <= bc_ok & (byte_w == 8'hFF);
                end
            end
            if (wr_d) begin
                addr_o <= cnt[BUF_ADDR_W-1:0];
                data_o <= byte_w;
            end else if (nxt == IDLE) begin
                addr_o <= '0;
            end
            if (to_done) begin
                len_o     <= cnt;
                crc_err_o <= crc != 32'hC704_DD7B;
                len_err_o <= int'(cnt) < MIN_LEN;
            end
            if (to_drop && drop_cnt_o != 16'hFFFF)
                drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_iob_eth_rx_mac.sv
// tb_iob_eth_rx_mac: directed frames into a nibble-mode and a byte-mode receiver.
module tb_iob_eth_rx_mac;

    localparam int NONE = -1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4_n, rst8_n, dv4, dv8, er, ack4, ack8, filt;
    logic [3:0]  d4;
    logic [7:0]  d8;
    logic [47:0] mac = 48'h02_11_22_33_44_66;

    logic        wr4, rcvd4, crc4, le4;
    logic [10:0] addr4;
    logic [7:0]  data4;
    logic [11:0] len4;
    logic [15:0] drop4;

    logic        wr8, rcvd8, crc8, le8;
    logic [5:0]  addr8;
    logic [7:0]  data8;
    logic [6:0]  len8;
    logic [15:0] drop8;

    int checks = 0, failures = 0, wc4 = 0, wc8 = 0, w0;
    logic [7:0] frm  [0:127];
    logic [7:0] mem4 [0:2047];
    logic [7:0] mem8 [0:63];

    iob_eth_rx_mac #(.DATA_W(4)) dut4 (
        .clk_i(clk), .arst_n_i(rst4_n), .rx_dv_i(dv4), .rx_er_i(er), .rx_data_i(d4),
        .filter_en_i(filt), .mac_addr_i(mac), .wr_o(wr4), .addr_o(addr4), .data_o(data4),
        .rcv_ack_i(ack4), .data_rcvd_o(rcvd4), .len_o(len4), .crc_err_o(crc4),
        .len_err_o(le4), .drop_cnt_o(drop4)
    );

    iob_eth_rx_mac #(.DATA_W(8), .BUF_ADDR_W(6)) dut8 (
        .clk_i(clk), .arst_n_i(rst8_n), .rx_dv_i(dv8), .rx_er_i(er), .rx_data_i(d8),
        .filter_en_i(filt), .mac_addr_i(mac), .wr_o(wr8), .addr_o(addr8), .data_o(data8),
        .rcv_ack_i(ack8), .data_rcvd_o(rcvd8), .len_o(len8), .crc_err_o(crc8),
        .len_err_o(le8), .drop_cnt_o(drop8)
    );

    always @(negedge clk) begin
        if (wr4) begin
            mem4[addr4] <= data4;
            wc4 <= wc4 + 1;
        end
        if (wr8) begin
            mem8[addr8] <= data8;
            wc8 <= wc8 + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference FCS in the reflected (LSB-first) form, transmitted low byte first
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = '1;
        for (int i = 0; i < n - 4; i++) begin
            c ^= {24'h0, frm[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] da, input int n, input bit flip);
        logic [31:0] f;
        for (int i = 0; i < n; i++)
            frm[i] = 8'(i) & 8'h3F;
        for (int i = 0; i < 6; i++)
            frm[i] = da[47-8*i -: 8];
        frm[6] = 8'h02; frm[7] = 8'h00; frm[8] = 8'h00;
        frm[9] = 8'h00; frm[10] = 8'h00; frm[11] = 8'h01;
        frm[12] = 8'h08; frm[13] = 8'h00;
        f = fcs_of(n);
        frm[n-4] = f[7:0]; frm[n-3] = f[15:8]; frm[n-2] = f[23:16]; frm[n-1] = f[31:24];
        if (flip)
            frm[n-1] ^= 8'h01;
    endtask

    task automatic send(input bit w8, input int n, input int er_at, input int ack_at, input int rst_at);
        int k;
        logic [7:0] b;
        k = 0;
        for (int i = 0; i < n + 8; i++) begin
            b = i < 7 ? 8'h55 : i == 7 ? 8'hD5 : frm[i-8];
            for (int h = 0; h < (w8 ? 1 : 2); h++) begin
                @(negedge clk);
                rst4_n = 1'b1;
                er = (i - 8 == er_at);
                if (w8) begin
                    dv8 = 1'b1; d8 = b; ack8 = (k == ack_at);
                end else begin
                    dv4 = 1'b1; d4 = h != 0 ? b[7:4] : b[3:0]; ack4 = (k == ack_at);
                end
                if (!w8 && h == 0 && i - 8 == rst_at) begin
                    rst4_n = 1'b0;
                    #1;
                    check("rst_mid", {wr4, addr4, data4, rcvd4, len4, crc4, le4, drop4}, 0);
                end
                k++;
            end
        end
        @(negedge clk);
        dv4 = 0; dv8 = 0; er = 0; ack4 = 0; ack8 = 0; rst4_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_done(input string tag, input bit w8, input int n, input int wc0,
                               input bit ecrc, input bit ele);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if ((w8 ? mem8[i] : mem4[i]) !== frm[i]) bad++;
        check({tag, "_wr"}, (w8 ? wc8 : wc4) - wc0, n);
        check({tag, "_data"}, bad, 0);
        check({tag, "_rcvd"}, w8 ? rcvd8 : rcvd4, 1);
        check({tag, "_len"}, w8 ? 64'(len8) : 64'(len4), n);
        check({tag, "_crc"}, w8 ? crc8 : crc4, ecrc);
        check({tag, "_lerr"}, w8 ? le8 : le4, ele);
    endtask

    task automatic ack(input bit w8);
        @(negedge clk);
        if (w8) ack8 = 1'b1; else ack4 = 1'b1;
        @(negedge clk);
        ack8 = 1'b0; ack4 = 1'b0;
        check(w8 ? "ack_clr8" : "ack_clr4", w8 ? rcvd8 : rcvd4, 0);
    endtask

    initial begin
        rst4_n = 0; rst8_n = 0; dv4 = 0; dv8 = 0; er = 0; ack4 = 0; ack8 = 0; filt = 0;
        d4 = '0; d8 = '0;
        repeat (2) @(negedge clk);
        check("rst4", {wr4, addr4, data4, rcvd4, len4, crc4, le4, drop4}, 0);
        check("rst8", {wr8, addr8, data8, rcvd8, len8, crc8, le8, drop8}, 0);
        rst4_n = 1; rst8_n = 1;
        @(negedge clk);

        build(mac, 64, 0); w0 = wc4;
        send(0, 64, NONE, NONE, NONE);
        expect_done("good4", 0, 64, w0, 0, 0);
        repeat (3) @(negedge clk);
        check("hold4", rcvd4, 1);
        check("hold4_wr", wc4 - w0, 64);
        ack(0);

        build(mac, 64, 1); w0 = wc8;
        send(1, 64, NONE, NONE, NONE);
        expect_done("fcs8", 1, 64, w0, 1, 0);
        ack(1);

        build(mac, 40, 0); w0 = wc8;
        send(1, 40, NONE, NONE, NONE);
        expect_done("short8", 1, 40, w0, 0, 1);
        ack(1);

        filt = 1;
        build(48'h02_11_22_33_44_67, 64, 0); w0 = wc8;
        send(1, 64, NONE, NONE, NONE);
        check("filt_wr", wc8 - w0, 6);
        check("filt_rcvd", rcvd8, 0);
        check("filt_drop", drop8, 1);

        build(48'hFF_FF_FF_FF_FF_FF, 64, 0); w0 = wc8;
        send(1, 64, NONE, NONE, NONE);
        expect_done("bcast8", 1, 64, w0, 0, 0);
        ack(1);
        filt = 0;

        build(mac, 64, 0); w0 = wc8;
        send(1, 64, 20, NONE, NONE);
        check("er_wr", wc8 - w0, 20);
        check("er_rcvd", rcvd8, 0);
        check("er_drop", drop8, 2);

        build(mac, 100, 0); w0 = wc8;
        send(1, 100, NONE, NONE, NONE);
        check("ovf_wr", wc8 - w0, 64);
        check("ovf_rcvd", rcvd8, 0);
        check("ovf_drop", drop8, 3);

        build(mac, 64, 0); w0 = wc4;
        send(0, 64, NONE, NONE, NONE);
        expect_done("a4", 0, 64, w0, 0, 0);
        w0 = wc4;
        send(0, 64, NONE, 3, NONE);
        check("ackdv_wr", wc4 - w0, 0);
        check("ackdv_rcvd", rcvd4, 0);
        check("ackdv_drop", drop4, 1);
        w0 = wc4;
        send(0, 64, NONE, NONE, NONE);
        expect_done("c4", 0, 64, w0, 0, 0);
        ack(0);

        w0 = wc4;
        send(0, 45, NONE, NONE, 30);
        check("rst_wr", wc4 - w0, 29);
        check("rst_rcvd", rcvd4, 0);
        w0 = wc4;
        send(0, 64, NONE, NONE, NONE);
        expect_done("post_rst4", 0, 64, w0, 0, 0);
        check("post_rst_drop", drop4, 0);
        ack(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
